// File: rtl/sim_ctrl_pkg.sv
// Shared types and default widths for the Boolean-network run controller.
// Holds the controller FSM encoding so the sim top and benches agree on it.
package sim_ctrl_pkg;

    localparam int STATE_W = 61;
    localparam int ITER_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        CAPT,
        EMIT,
        DONE
    } sim_state_e;

endpackage

// File: rtl/network_sim_sequencer.sv
// Run controller: iterates network_logic from init_state until fixed point or max_iter.
// 3 cycles/iteration (EVAL, CAPT, EMIT); trace_ready low stalls in EMIT with outputs held.
module network_sim_sequencer
    import sim_ctrl_pkg::*;
#(
    parameter int STATE_W = sim_ctrl_pkg::STATE_W,
    parameter int ITER_W  = sim_ctrl_pkg::ITER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] init_state,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic [ITER_W-1:0]  min_iter,
    output logic [STATE_W-1:0] net_current_state,
    output logic [ITER_W-1:0]  net_iteration,
    input  logic [STATE_W-1:0] net_next_state,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [STATE_W-1:0] trace_state,
    output logic [ITER_W-1:0]  trace_iter,
    output logic               busy,
    output logic               done,
    output logic               converged
);

    sim_state_e         state;
    sim_state_e         state_nxt;
    logic [STATE_W-1:0] state_reg;
    logic [ITER_W-1:0]  iter;
    logic [ITER_W-1:0]  max_lat;
    logic [ITER_W-1:0]  min_lat;
    logic               fixed;
    logic               conv_hit;
    logic               limit_hit;

    // Convergence only counts once the evaluator's input-toggle window has passed.
    assign conv_hit  = fixed && (iter > min_lat);
    assign limit_hit = (iter == max_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (max_iter == '0) ? DONE : EVAL;
                end
            end
            EVAL: state_nxt = CAPT;
            CAPT: state_nxt = EMIT;
            EMIT: begin
                if (trace_ready) begin
                    if (conv_hit || limit_hit) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = EVAL;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            iter      <= '0;
            max_lat   <= '0;
            min_lat   <= '0;
            fixed     <= 1'b0;
            converged <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_reg <= init_state;
                        iter      <= '0;
                        max_lat   <= max_iter;
                        min_lat   <= min_iter;
                        fixed     <= 1'b0;
                        converged <= 1'b0;
                    end
                end
                CAPT: begin
                    state_reg <= net_next_state;
                    fixed     <= (net_next_state == state_reg);
                    iter      <= iter + 1'b1;
                end
                EMIT: begin
                    if (trace_ready && conv_hit) begin
                        converged <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign net_current_state = state_reg;
    assign net_iteration     = iter;
    assign trace_state       = state_reg;
    assign trace_iter        = iter;
    assign trace_valid       = (state == EMIT);
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);

endmodule
